// File: rtl/el2_exu_div_receiver_pkg.sv
// rtl/el2_exu_div_receiver_pkg.sv - shared types and constants for the EXU divide NoC receive path
//
// Purpose: owns the divider request descriptor, the NoC node address of the
// divide wrapper, the header field offsets, the deserializer state encoding
// and the flit-count helper shared by sender and receiver.
// Ports: none (package).
package el2_exu_div_receiver_pkg;

  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } el2_div_pkt_t;

  localparam int NOC_ADDR_BITS = 8;
  localparam logic [NOC_ADDR_BITS-1:0] POS_DIV_WRAPPER = 8'h03;

  // Header flit: destination address in the low bits, padding right above it.
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_PAD_LSB  = HDR_ADDR_LSB + NOC_ADDR_BITS;

  typedef enum logic [1:0] {
    RX_HDR  = 2'd0,
    RX_PAY  = 2'd1,
    RX_DROP = 2'd2,
    RX_HOLD = 2'd3
  } rx_state_t;

  function automatic int noc_num_flits(input int packet_bits, input int data_bits);
    return (packet_bits + data_bits - 1) / data_bits;
  endfunction

endpackage

// File: rtl/el2_exu_div_receiver_if.sv
// rtl/el2_exu_div_receiver_if.sv - flit input and divider request bundle
//
// Purpose: groups the NoC flit stream, the divider valid/ready request and the
// status pulses of the divide receiver.
// Modports: slave  - the receiver (consumes flits, drives the request)
//           master - the environment (drives flits, takes the request)
interface el2_exu_div_receiver_if #(
  parameter int DATA_BITS = 32
) ();

  logic                                       noc_valid;
  logic [DATA_BITS-1:0]                       noc_data;
  logic                                       noc_last;
  logic                                       noc_ready;
  logic                                       div_valid;
  logic                                       div_ready;
  el2_exu_div_receiver_pkg::el2_div_pkt_t     div_dp;
  logic                                       div_cancel;
  logic [31:0]                                div_dividend;
  logic [31:0]                                div_divisor;
  logic                                       pkt_ack;
  logic                                       pkt_drop;
  logic                                       pkt_err;

  modport slave (
    input  noc_valid, noc_data, noc_last, div_ready,
    output noc_ready, div_valid, div_dp, div_cancel, div_dividend, div_divisor,
           pkt_ack, pkt_drop, pkt_err
  );

  modport master (
    output noc_valid, noc_data, noc_last, div_ready,
    input  noc_ready, div_valid, div_dp, div_cancel, div_dividend, div_divisor,
           pkt_ack, pkt_drop, pkt_err
  );

endinterface

// File: rtl/el2_exu_div_receiver_noc_serial_receiver.sv
// rtl/el2_exu_div_receiver_noc_serial_receiver.sv - generic NoC flit deserializer with output register
//
// Purpose: accepts a header flit plus NUM_FLITS payload flits (MSB first),
// filters on destination address, checks framing and presents
// {padding, packet} through a valid/ready output register.
// Ports: clk, rst (async, active high); noc_valid_i/noc_data_i/noc_last_i/
// noc_ready_o flit input; out_valid_o/out_ready_i/out_data_o request output;
// pkt_ack_o/pkt_drop_o/pkt_err_o registered one-cycle status pulses.
module noc_serial_receiver
  import el2_exu_div_receiver_pkg::*;
#(
  parameter int                   DATA_BITS    = 32,
  parameter int                   PACKET_BITS  = 64,
  parameter int                   PADDING_BITS = 4,
  parameter int                   ADDR_BITS    = 8,
  parameter logic [ADDR_BITS-1:0] MY_ADDR      = '0,
  parameter int                   ADDR_LSB     = HDR_ADDR_LSB,
  parameter int                   PAD_LSB      = HDR_PAD_LSB
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  noc_valid_i,
  input  logic [DATA_BITS-1:0]                  noc_data_i,
  input  logic                                  noc_last_i,
  output logic                                  noc_ready_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [PADDING_BITS+PACKET_BITS-1:0]   out_data_o,
  output logic                                  pkt_ack_o,
  output logic                                  pkt_drop_o,
  output logic                                  pkt_err_o
);

  localparam int NUM_FLITS = noc_num_flits(PACKET_BITS, DATA_BITS);
  localparam int ASM_BITS  = NUM_FLITS * DATA_BITS;
  localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FLITS - 1);

  rx_state_t                             state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [PADDING_BITS-1:0]               pad_q, pad_d;
  logic [ASM_BITS-1:0]                   asm_q, asm_d;
  logic                                  drop_addr_q, drop_addr_d;
  logic                                  out_valid_q, out_valid_d;
  logic [PADDING_BITS+PACKET_BITS-1:0]   out_data_q, out_data_d;
  logic                                  ack_q, ack_d;
  logic                                  drop_q, drop_d;
  logic                                  err_q, err_d;

  logic                                  flit_acc;
  logic                                  out_fire;
  logic [ASM_BITS-1:0]                   shifted;

  assign noc_ready_o = (state_q != RX_HOLD);
  assign flit_acc    = noc_valid_i & noc_ready_o;
  assign out_fire    = out_valid_q & out_ready_i;
  // Assembly view including the flit on the bus, so the last flit can be
  // loaded straight into the output register without an extra cycle.
  assign shifted     = (asm_q << DATA_BITS) | ASM_BITS'(noc_data_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pad_d       = pad_q;
    asm_d       = asm_q;
    drop_addr_d = drop_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack_d       = out_fire;
    drop_d      = 1'b0;
    err_d       = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      RX_HDR: begin
        if (flit_acc) begin
          cnt_d = '0;
          if (noc_last_i) begin
            err_d = 1'b1;
          end else if (noc_data_i[ADDR_LSB +: ADDR_BITS] != MY_ADDR) begin
            drop_addr_d = 1'b1;
            state_d     = RX_DROP;
          end else begin
            pad_d   = noc_data_i[PAD_LSB +: PADDING_BITS];
            state_d = RX_PAY;
          end
        end
      end
      RX_PAY: begin
        if (flit_acc) begin
          asm_d = shifted;
          if (cnt_q == LAST_CNT) begin
            if (noc_last_i) begin
              // Empty register, or the current request leaves this cycle.
              if (!out_valid_q || out_ready_i) begin
                out_valid_d = 1'b1;
                out_data_d  = {pad_q, shifted[PACKET_BITS-1:0]};
                state_d     = RX_HDR;
              end else begin
                state_d = RX_HOLD;
              end
            end else begin
              // Overlong packet: report once, then swallow up to its last flit.
              err_d       = 1'b1;
              drop_addr_d = 1'b0;
              state_d     = RX_DROP;
            end
          end else if (noc_last_i) begin
            err_d   = 1'b1;
            state_d = RX_HDR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RX_DROP: begin
        if (flit_acc && noc_last_i) begin
          drop_d  = drop_addr_q;
          state_d = RX_HDR;
        end
      end
      RX_HOLD: begin
        if (out_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = {pad_q, asm_q[PACKET_BITS-1:0]};
          state_d     = RX_HDR;
        end
      end
      default: state_d = RX_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_HDR;
      cnt_q       <= '0;
      pad_q       <= '0;
      asm_q       <= '0;
      drop_addr_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ack_q       <= 1'b0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pad_q       <= pad_d;
      asm_q       <= asm_d;
      drop_addr_q <= drop_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ack_q       <= ack_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign pkt_ack_o   = ack_q;
  assign pkt_drop_o  = drop_q;
  assign pkt_err_o   = err_q;

endmodule

// File: rtl/el2_exu_div_receiver.sv
// rtl/el2_exu_div_receiver.sv - EXU divide NoC receiver at node POS_DIV_WRAPPER
//
// Purpose: deserializes divide request packets addressed to this node and
// presents {dp, cancel, dividend, divisor} to the divider core.
// Ports: clk, rst (async, active high); bus (slave modport) carrying the flit
// input, the divider valid/ready request and the ack/drop/err pulses.
module el2_exu_div_receiver
  import el2_exu_div_receiver_pkg::*;
#(
  parameter int                   DATA_BITS    = 32,
  parameter int                   PACKET_BITS  = 64,
  parameter int                   PADDING_BITS = $bits(el2_div_pkt_t) + 1,
  parameter int                   ADDR_BITS    = NOC_ADDR_BITS,
  parameter logic [ADDR_BITS-1:0] MY_ADDR      = ADDR_BITS'(POS_DIV_WRAPPER)
) (
  input logic                   clk,
  input logic                   rst,
  el2_exu_div_receiver_if.slave bus
);

  logic [PADDING_BITS+PACKET_BITS-1:0] rx_data;
  logic [PADDING_BITS-1:0]             rx_pad;

  noc_serial_receiver #(
    .DATA_BITS    (DATA_BITS),
    .PACKET_BITS  (PACKET_BITS),
    .PADDING_BITS (PADDING_BITS),
    .ADDR_BITS    (ADDR_BITS),
    .MY_ADDR      (MY_ADDR),
    .ADDR_LSB     (HDR_ADDR_LSB),
    .PAD_LSB      (HDR_ADDR_LSB + ADDR_BITS)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .noc_valid_i (bus.noc_valid),
    .noc_data_i  (bus.noc_data),
    .noc_last_i  (bus.noc_last),
    .noc_ready_o (bus.noc_ready),
    .out_valid_o (bus.div_valid),
    .out_ready_i (bus.div_ready),
    .out_data_o  (rx_data),
    .pkt_ack_o   (bus.pkt_ack),
    .pkt_drop_o  (bus.pkt_drop),
    .pkt_err_o   (bus.pkt_err)
  );

  // Padding is {valid, unsign, rem, cancel}; packet is {dividend, divisor}.
  assign rx_pad           = rx_data[PACKET_BITS +: PADDING_BITS];
  assign bus.div_dp       = el2_div_pkt_t'(rx_pad[PADDING_BITS-1:1]);
  assign bus.div_cancel   = rx_pad[0];
  assign bus.div_dividend = rx_data[PACKET_BITS-1 -: 32];
  assign bus.div_divisor  = rx_data[31:0];

endmodule

// File: tb/tb_el2_exu_div_receiver.sv
// tb/tb_el2_exu_div_receiver.sv - self-checking bench for el2_exu_div_receiver
module tb_el2_exu_div_receiver;

  localparam logic [7:0] MY  = el2_exu_div_receiver_pkg::POS_DIV_WRAPPER;
  localparam logic [7:0] BAD = 8'h05;

  logic clk;
  logic rst;

  el2_exu_div_receiver_if bus ();

  el2_exu_div_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int ack_cnt;
  int drop_cnt;
  int err_cnt;
  logic [67:0] cap[$];

  always @(negedge clk) begin
    if (bus.div_valid === 1'b1 && bus.div_ready === 1'b1)
      cap.push_back({bus.div_dp, bus.div_cancel, bus.div_dividend, bus.div_divisor});
    if (bus.pkt_ack === 1'b1)  ack_cnt++;
    if (bus.pkt_drop === 1'b1) drop_cnt++;
    if (bus.pkt_err === 1'b1)  err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.noc_valid = 1'b1;
    bus.noc_data  = d;
    bus.noc_last  = l;
    @(negedge clk);
    while (bus.noc_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL noc_ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    #1;
    bus.noc_valid = 1'b0;
    bus.noc_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [3:0] p,
                          input logic [31:0] dvd, input logic [31:0] dvs);
    send_flit({20'h0, p, a}, 1'b0);
    send_flit(dvd, 1'b0);
    send_flit(dvs, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  pad;
    logic [31:0] dvd;
    logic [31:0] dvs;
    bit          deliver;
    bit          drop;
    logic [2:0]  exp_dp;
    logic        exp_cancel;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int a0, d0, e0;

    vecs[0] = '{MY,  4'b1010, 32'd100,        32'd7,        1'b1, 1'b0, 3'b101, 1'b0};
    vecs[1] = '{MY,  4'b1101, 32'hDEADBEEF,   32'h12345678, 1'b1, 1'b0, 3'b110, 1'b1};
    vecs[2] = '{MY,  4'b0111, 32'hFFFFFFFF,   32'h0,        1'b1, 1'b0, 3'b011, 1'b1};
    vecs[3] = '{BAD, 4'b1111, 32'h1,          32'h2,        1'b0, 1'b1, 3'b000, 1'b0};
    vecs[4] = '{MY,  4'b1000, 32'h80000000,   32'h1,        1'b1, 1'b0, 3'b100, 1'b0};

    total = 0; bad = 0; ack_cnt = 0; drop_cnt = 0; err_cnt = 0;
    bus.noc_valid = 1'b0;
    bus.noc_data  = '0;
    bus.noc_last  = 1'b0;
    bus.div_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_div_valid", bus.div_valid, 0);
    chk("rst_noc_ready", bus.noc_ready, 1);
    chk("rst_pulses", {bus.pkt_ack, bus.pkt_drop, bus.pkt_err}, 0);
    chk("rst_data", {bus.div_dp, bus.div_cancel, bus.div_dividend, bus.div_divisor}, 0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Table-driven packets with the divider always ready.
    bus.div_ready = 1'b1;
    foreach (vecs[i]) begin
      a0 = ack_cnt; d0 = drop_cnt; e0 = err_cnt;
      cap.delete();
      send_pkt(vecs[i].addr, vecs[i].pad, vecs[i].dvd, vecs[i].dvs);
      idle(3);
      chk($sformatf("v%0d_count", i), cap.size(), vecs[i].deliver ? 1 : 0);
      if (vecs[i].deliver && cap.size() > 0)
        chk($sformatf("v%0d_data", i), cap[0],
            {vecs[i].exp_dp, vecs[i].exp_cancel, vecs[i].dvd, vecs[i].dvs});
      chk($sformatf("v%0d_ack", i),  ack_cnt - a0,  vecs[i].deliver ? 1 : 0);
      chk($sformatf("v%0d_drop", i), drop_cnt - d0, vecs[i].drop ? 1 : 0);
      chk($sformatf("v%0d_err", i),  err_cnt - e0,  0);
    end

    // Latency and backpressure into HOLD.
    bus.div_ready = 1'b0;
    cap.delete();
    a0 = ack_cnt;
    send_pkt(MY, 4'b1010, 32'd100, 32'd7);
    chk("lat_valid", bus.div_valid, 1);
    chk("lat_data", {bus.div_dp, bus.div_cancel, bus.div_dividend, bus.div_divisor},
        {3'b101, 1'b0, 32'd100, 32'd7});
    send_pkt(MY, 4'b0000, 32'd5, 32'd3);
    chk("bp_hold_ready", bus.noc_ready, 0);
    idle(2);
    chk("bp_stable", bus.div_dividend, 100);
    chk("bp_no_ack", ack_cnt - a0, 0);
    bus.div_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before", bus.noc_ready, 0);
    @(negedge clk);
    chk("bp_ready_after", bus.noc_ready, 1);
    chk("bp_second_loaded", bus.div_dividend, 5);
    idle(3);
    chk("bp_count", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("bp_first", cap[0], {3'b101, 1'b0, 32'd100, 32'd7});
      chk("bp_second", cap[1], {3'b000, 1'b0, 32'd5, 32'd3});
    end
    chk("bp_acks", ack_cnt - a0, 2);

    // Asynchronous reset with a pending request.
    bus.div_ready = 1'b0;
    send_pkt(MY, 4'b1111, 32'd9, 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.div_valid, 0);
    chk("arst_data", {bus.div_dp, bus.div_cancel, bus.div_dividend, bus.div_divisor}, 0);
    chk("arst_ready", bus.noc_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Last flit coincides with the handshake of a full register.
    cap.delete();
    send_pkt(MY, 4'b0100, 32'd11, 32'd2);
    send_flit({20'h0, 4'b0010, MY}, 1'b0);
    send_flit(32'd21, 1'b0);
    bus.div_ready = 1'b1;
    send_flit(32'd4, 1'b1);
    chk("sim_ready", bus.noc_ready, 1);
    chk("sim_new", {bus.div_valid, bus.div_dividend, bus.div_divisor}, {1'b1, 32'd21, 32'd4});
    idle(3);
    chk("sim_count", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("sim_first", cap[0], {3'b010, 1'b0, 32'd11, 32'd2});
      chk("sim_second", cap[1], {3'b001, 1'b0, 32'd21, 32'd4});
    end

    // Early last on the first payload flit, then a good packet.
    cap.delete();
    e0 = err_cnt; d0 = drop_cnt;
    send_flit({20'h0, 4'b1000, MY}, 1'b0);
    send_flit(32'h1234, 1'b1);
    idle(3);
    chk("early_err", err_cnt - e0, 1);
    chk("early_none", cap.size(), 0);
    send_pkt(MY, 4'b1000, 32'h40, 32'h8);
    idle(3);
    chk("early_next_count", cap.size(), 1);
    if (cap.size() == 1)
      chk("early_next_data", cap[0], {3'b100, 1'b0, 32'h40, 32'h8});

    // Header carrying last.
    e0 = err_cnt;
    send_flit({20'h0, 4'b1000, MY}, 1'b1);
    idle(2);
    chk("hdr_last_err", err_cnt - e0, 1);

    // Missing last on the final payload flit: error, no drop, nothing out.
    cap.delete();
    e0 = err_cnt; d0 = drop_cnt;
    send_flit({20'h0, 4'b1000, MY}, 1'b0);
    send_flit(32'h1, 1'b0);
    send_flit(32'h2, 1'b0);
    send_flit(32'h3, 1'b1);
    idle(3);
    chk("long_err", err_cnt - e0, 1);
    chk("long_drop", drop_cnt - d0, 0);
    chk("long_none", cap.size(), 0);

    // Reset mid-packet, then a full packet must arrive intact.
    cap.delete();
    send_flit({20'h0, 4'b1000, MY}, 1'b0);
    send_flit(32'hAAAA, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", bus.noc_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    send_pkt(MY, 4'b1001, 32'hFFFFFFF9, 32'h2);
    idle(3);
    chk("mid_rst_count", cap.size(), 1);
    if (cap.size() == 1)
      chk("mid_rst_data", cap[0], {3'b100, 1'b1, 32'hFFFFFFF9, 32'h2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
